// File: rtl/touch_frame_locker_pkg.sv
// touch_frame_locker_pkg
// Shared definitions for the touch frame locker slice: coordinate width,
// the coordinate value that means "no touch", the debounce state encoding
// and a small helper that tells whether a state counts as touching.
package touch_frame_locker_pkg;

  localparam int TOUCH_W = 12;
  localparam logic [TOUCH_W-1:0] NO_TOUCH_DEFAULT = 12'd1000;

  typedef enum logic [1:0] {
    ST_RELEASED     = 2'd0,
    ST_PRESS_PEND   = 2'd1,
    ST_PRESSED      = 2'd2,
    ST_RELEASE_PEND = 2'd3
  } deb_state_e;

  // A pending release still counts as touching: the finger has not been
  // confirmed gone yet, so averaging and frame locking keep using it.
  function automatic logic is_touching(input deb_state_e st);
    return (st == ST_PRESSED) || (st == ST_RELEASE_PEND);
  endfunction

endpackage

// File: rtl/touch_calib.sv
// touch_calib
// Saturating offset-and-shift calibration for one axis.
//   avg : averaged raw coordinate
//   cal : (avg - OFFSET) >> SHIFT, or 0 when avg <= OFFSET (never wraps)
module touch_calib
  import touch_frame_locker_pkg::*;
#(
  parameter int OFFSET = 150,
  parameter int SHIFT  = 3
) (
  input  logic [TOUCH_W-1:0] avg,
  output logic [TOUCH_W-1:0] cal
);

  localparam logic [TOUCH_W-1:0] OFFSET_C = TOUCH_W'(OFFSET);

  // Saturating subtract then shift.
  always_comb begin
    if (avg > OFFSET_C) begin
      cal = (avg - OFFSET_C) >> SHIFT;
    end else begin
      cal = {TOUCH_W{1'b0}};
    end
  end

endmodule

// File: rtl/touch_frame_locker.sv
// touch_frame_locker
// Samples the touchpad controller on a periodic tick, debounces press/release
// on pressure, box-car averages pressed samples, calibrates them and reloads
// the output coordinates only on new_frame rising edges.
// Ports:
//   cclk, rstb      : clock, asynchronous active-low reset
//   touch_x/y/z     : raw 12-bit coordinates and pressure
//   new_frame       : frame marker (level or pulse), cclk domain
//   locked_x/y      : calibrated coordinates, stable between frame edges
//   touch_active    : debounced press state latched at the last frame edge
//   frame_update    : one-cycle pulse when locked_* were reloaded
// Build option: TOUCH_FRAME_LOCKER_HOLD_EN keeps the last touched coordinates
// on release instead of driving NO_TOUCH.
module touch_frame_locker
  import touch_frame_locker_pkg::*;
#(
  parameter int SAMPLE_PERIOD = 1000,
  parameter int AVG_LOG2      = 2,
  parameter int DEB_COUNT     = 3,
  parameter int Z_THRESH      = 256,
  parameter int X_OFFSET      = 150,
  parameter int Y_OFFSET      = 300,
  parameter int X_SHIFT       = 3,
  parameter int Y_SHIFT       = 4,
  parameter int NO_TOUCH      = int'(NO_TOUCH_DEFAULT)
) (
  input  logic               cclk,
  input  logic               rstb,
  input  logic [TOUCH_W-1:0] touch_x,
  input  logic [TOUCH_W-1:0] touch_y,
  input  logic [TOUCH_W-1:0] touch_z,
  input  logic               new_frame,
  output logic [TOUCH_W-1:0] locked_x,
  output logic [TOUCH_W-1:0] locked_y,
  output logic               touch_active,
  output logic               frame_update
);

  localparam int CNT_W = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SAMPLE_PERIOD - 1);
  localparam int SUM_W = TOUCH_W + AVG_LOG2;
  localparam int WIN_W = AVG_LOG2 + 1;
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'((1 << AVG_LOG2) - 1);
  localparam logic [3:0] DEB_C = 4'(DEB_COUNT);
  localparam logic [TOUCH_W-1:0] Z_THRESH_C = TOUCH_W'(Z_THRESH);
  localparam logic [TOUCH_W-1:0] NO_TOUCH_C = TOUCH_W'(NO_TOUCH);

  logic [CNT_W-1:0]   smp_cnt_r;
  logic               sample_tick_s;
  logic [TOUCH_W-1:0] x_reg_r, y_reg_r, z_reg_r;
  logic               eval_r;
  logic               pressed_s;
  deb_state_e         state_r, state_nxt_s;
  logic [3:0]         deb_cnt_r, deb_cnt_nxt_s;
  logic [SUM_W-1:0]   sum_x_r, sum_y_r, sum_x_nxt_s, sum_y_nxt_s;
  logic [WIN_W-1:0]   win_cnt_r;
  logic [TOUCH_W-1:0] avg_x_r, avg_y_r;
  logic               avg_ok_r;
  logic               accum_s, enter_rel_s;
  logic [TOUCH_W-1:0] cx_s, cy_s;
  logic               new_frame_q_r, frame_rise_s, active_nxt_s;

  assign sample_tick_s = (smp_cnt_r == CNT_LAST);
  assign pressed_s     = (z_reg_r >= Z_THRESH_C);

  // Free-running sample period counter.
  always_ff @(posedge cclk or negedge rstb) begin
    if (!rstb) begin
      smp_cnt_r <= {CNT_W{1'b0}};
    end else if (sample_tick_s) begin
      smp_cnt_r <= {CNT_W{1'b0}};
    end else begin
      smp_cnt_r <= smp_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  // Raw capture on the tick; eval_r marks the following cycle as the
  // one where the captured sample is judged.
  always_ff @(posedge cclk or negedge rstb) begin
    if (!rstb) begin
      x_reg_r <= {TOUCH_W{1'b0}};
      y_reg_r <= {TOUCH_W{1'b0}};
      z_reg_r <= {TOUCH_W{1'b0}};
      eval_r  <= 1'b0;
    end else begin
      eval_r <= sample_tick_s;
      if (sample_tick_s) begin
        x_reg_r <= touch_x;
        y_reg_r <= touch_y;
        z_reg_r <= touch_z;
      end
    end
  end

  // Debounce next-state logic, advancing only on evaluated samples.
  always_comb begin
    state_nxt_s   = state_r;
    deb_cnt_nxt_s = deb_cnt_r;
    if (eval_r) begin
      case (state_r)
        ST_RELEASED: begin
          if (pressed_s) begin
            if (DEB_C == 4'd1) begin
              state_nxt_s   = ST_PRESSED;
              deb_cnt_nxt_s = 4'd0;
            end else begin
              state_nxt_s   = ST_PRESS_PEND;
              deb_cnt_nxt_s = 4'd1;
            end
          end else begin
            deb_cnt_nxt_s = 4'd0;
          end
        end
        ST_PRESS_PEND: begin
          if (!pressed_s) begin
            state_nxt_s   = ST_RELEASED;
            deb_cnt_nxt_s = 4'd0;
          end else if ((deb_cnt_r + 4'd1) == DEB_C) begin
            state_nxt_s   = ST_PRESSED;
            deb_cnt_nxt_s = 4'd0;
          end else begin
            deb_cnt_nxt_s = deb_cnt_r + 4'd1;
          end
        end
        ST_PRESSED: begin
          if (!pressed_s) begin
            if (DEB_C == 4'd1) begin
              state_nxt_s   = ST_RELEASED;
              deb_cnt_nxt_s = 4'd0;
            end else begin
              state_nxt_s   = ST_RELEASE_PEND;
              deb_cnt_nxt_s = 4'd1;
            end
          end else begin
            deb_cnt_nxt_s = 4'd0;
          end
        end
        ST_RELEASE_PEND: begin
          if (pressed_s) begin
            state_nxt_s   = ST_PRESSED;
            deb_cnt_nxt_s = 4'd0;
          end else if ((deb_cnt_r + 4'd1) == DEB_C) begin
            state_nxt_s   = ST_RELEASED;
            deb_cnt_nxt_s = 4'd0;
          end else begin
            deb_cnt_nxt_s = deb_cnt_r + 4'd1;
          end
        end
        default: begin
          state_nxt_s   = ST_RELEASED;
          deb_cnt_nxt_s = 4'd0;
        end
      endcase
    end else begin
      state_nxt_s   = state_r;
      deb_cnt_nxt_s = deb_cnt_r;
    end
  end

  // Debounce state registers.
  always_ff @(posedge cclk or negedge rstb) begin
    if (!rstb) begin
      state_r   <= ST_RELEASED;
      deb_cnt_r <= 4'd0;
    end else begin
      state_r   <= state_nxt_s;
      deb_cnt_r <= deb_cnt_nxt_s;
    end
  end

  // Accumulate only pressed samples while touching; the state used is the
  // one before this sample's transition.
  assign accum_s     = eval_r & pressed_s & is_touching(state_r);
  assign enter_rel_s = (state_nxt_s == ST_RELEASED) && (state_r != ST_RELEASED);
  assign sum_x_nxt_s = sum_x_r + SUM_W'(x_reg_r);
  assign sum_y_nxt_s = sum_y_r + SUM_W'(y_reg_r);

  // Box-car averager over 2^AVG_LOG2 accepted samples.
  always_ff @(posedge cclk or negedge rstb) begin
    if (!rstb) begin
      sum_x_r   <= {SUM_W{1'b0}};
      sum_y_r   <= {SUM_W{1'b0}};
      win_cnt_r <= {WIN_W{1'b0}};
      avg_x_r   <= {TOUCH_W{1'b0}};
      avg_y_r   <= {TOUCH_W{1'b0}};
      avg_ok_r  <= 1'b0;
    end else if (enter_rel_s) begin
      sum_x_r   <= {SUM_W{1'b0}};
      sum_y_r   <= {SUM_W{1'b0}};
      win_cnt_r <= {WIN_W{1'b0}};
      avg_ok_r  <= 1'b0;
    end else if (accum_s) begin
      if (win_cnt_r == WIN_LAST) begin
        avg_x_r   <= sum_x_nxt_s[AVG_LOG2 +: TOUCH_W];
        avg_y_r   <= sum_y_nxt_s[AVG_LOG2 +: TOUCH_W];
        avg_ok_r  <= 1'b1;
        sum_x_r   <= {SUM_W{1'b0}};
        sum_y_r   <= {SUM_W{1'b0}};
        win_cnt_r <= {WIN_W{1'b0}};
      end else begin
        sum_x_r   <= sum_x_nxt_s;
        sum_y_r   <= sum_y_nxt_s;
        win_cnt_r <= win_cnt_r + {{AVG_LOG2{1'b0}}, 1'b1};
      end
    end
  end

  touch_calib #(.OFFSET(X_OFFSET), .SHIFT(X_SHIFT)) u_calib_x (.avg(avg_x_r), .cal(cx_s));
  touch_calib #(.OFFSET(Y_OFFSET), .SHIFT(Y_SHIFT)) u_calib_y (.avg(avg_y_r), .cal(cy_s));

  // Frame-edge detection uses registered state/avg, so simultaneous state
  // changes or average completions show up only at the next frame.
  assign frame_rise_s = new_frame & ~new_frame_q_r;
  assign active_nxt_s = is_touching(state_r) & avg_ok_r;

  // Output lock: outputs change only here, on a new_frame rising edge.
  always_ff @(posedge cclk or negedge rstb) begin
    if (!rstb) begin
      new_frame_q_r <= 1'b0;
      frame_update  <= 1'b0;
      touch_active  <= 1'b0;
      locked_x      <= NO_TOUCH_C;
      locked_y      <= NO_TOUCH_C;
    end else begin
      new_frame_q_r <= new_frame;
      frame_update  <= frame_rise_s;
      if (frame_rise_s) begin
        touch_active <= active_nxt_s;
        if (active_nxt_s) begin
          locked_x <= cx_s;
          locked_y <= cy_s;
        end else begin
`ifdef TOUCH_FRAME_LOCKER_HOLD_EN
          locked_x <= locked_x;
          locked_y <= locked_y;
`else
          locked_x <= NO_TOUCH_C;
          locked_y <= NO_TOUCH_C;
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_touch_frame_locker.sv
// tb_touch_frame_locker
// Directed bench for touch_frame_locker with an 8-cycle sample period.
// Inputs only ever change in whole sample periods after reset release, so
// every captured sample sees exactly the value written for it.
module tb_touch_frame_locker;

  localparam int SP = 8;

  logic        cclk = 1'b0;
  logic        rstb;
  logic [11:0] touch_x, touch_y, touch_z;
  logic        new_frame;
  logic [11:0] locked_x, locked_y;
  logic        touch_active, frame_update;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;
  logic [11:0] rel_x, rel_y;

  always #5 cclk = ~cclk;

  touch_frame_locker #(.SAMPLE_PERIOD(SP)) dut (
    .cclk(cclk), .rstb(rstb),
    .touch_x(touch_x), .touch_y(touch_y), .touch_z(touch_z),
    .new_frame(new_frame),
    .locked_x(locked_x), .locked_y(locked_y),
    .touch_active(touch_active), .frame_update(frame_update)
  );

  task automatic check(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step_samples(input int n);
    repeat (SP * n) @(posedge cclk);
    #1;
  endtask

  // One-cycle new_frame pulse spanning exactly one sample period.
  task automatic frame_pulse(input string tag, input logic [11:0] ex,
                             input logic [11:0] ey, input logic ea);
    @(posedge cclk); #1;
    new_frame = 1'b1;
    @(posedge cclk); #1;
    new_frame = 1'b0;
    check({tag, ".upd"}, {11'd0, frame_update}, 12'd1);
    check({tag, ".x"}, locked_x, ex);
    check({tag, ".y"}, locked_y, ey);
    check({tag, ".act"}, {11'd0, touch_active}, {11'd0, ea});
    @(posedge cclk); #1;
    check({tag, ".upd_end"}, {11'd0, frame_update}, 12'd0);
    repeat (SP - 3) @(posedge cclk);
    #1;
  endtask

  initial begin
    int pulses;
`ifdef TOUCH_FRAME_LOCKER_HOLD_EN
    rel_x = 12'd150;
    rel_y = 12'd100;
`else
    rel_x = 12'd1000;
    rel_y = 12'd1000;
`endif
    rstb      = 1'b0;
    new_frame = 1'b0;
    touch_x   = 12'd1350;
    touch_y   = 12'd1900;
    touch_z   = 12'd600;
    repeat (3) @(posedge cclk);
    @(negedge cclk);
    check("rst.x", locked_x, 12'd1000);
    check("rst.y", locked_y, 12'd1000);
    check("rst.act", {11'd0, touch_active}, 12'd0);
    check("rst.upd", {11'd0, frame_update}, 12'd0);
    rstb = 1'b1;

    // Steady press: 3 debounce samples then a full window of 4.
    step_samples(8);
    check("pre_frame.x", locked_x, 12'd1000);
    check("pre_frame.act", {11'd0, touch_active}, 12'd0);
    frame_pulse("steady", 12'd150, 12'd100, 1'b1);

    // Mid-frame coordinate change must not reach the outputs.
    touch_x = 12'd2150;
    step_samples(1);
    check("midframe.x", locked_x, 12'd150);

    // new_frame held high for 50 cycles: a single reload, window not yet done.
    @(posedge cclk); #1;
    new_frame = 1'b1;
    pulses = 0;
    repeat (50) begin
      @(posedge cclk); #1;
      if (frame_update) pulses++;
    end
    new_frame = 1'b0;
    repeat (5) begin
      @(posedge cclk); #1;
      if (frame_update) pulses++;
    end
    check("held.pulses", 12'(pulses), 12'd1);
    check("held.x", locked_x, 12'd150);
    check("held.y", locked_y, 12'd100);
    frame_pulse("newwin", 12'd250, 12'd100, 1'b1);

    touch_x = 12'd1350;
    step_samples(8);
    frame_pulse("restore", 12'd150, 12'd100, 1'b1);

    // Release after three low samples.
    touch_z = 12'd0;
    step_samples(3);
    frame_pulse("release", rel_x, rel_y, 1'b0);

    // Bounce never reaches PRESSED.
    for (int i = 0; i < 4; i++) begin
      touch_z = 12'd600;
      step_samples(1);
      touch_z = 12'd0;
      step_samples(1);
    end
    frame_pulse("bounce1", rel_x, rel_y, 1'b0);
    frame_pulse("bounce2", rel_x, rel_y, 1'b0);

    // Saturating calibration below the offsets.
    touch_x = 12'd100;
    touch_y = 12'd200;
    touch_z = 12'd600;
    step_samples(8);
    frame_pulse("sat", 12'd0, 12'd0, 1'b1);

    // Asynchronous reset while pressed.
    #2 rstb = 1'b0;
    #1;
    check("rst_mid.x", locked_x, 12'd1000);
    check("rst_mid.y", locked_y, 12'd1000);
    check("rst_mid.act", {11'd0, touch_active}, 12'd0);
    check("rst_mid.upd", {11'd0, frame_update}, 12'd0);
    @(negedge cclk);
    rstb = 1'b1;
    step_samples(2);
    frame_pulse("restart_pend", 12'd1000, 12'd1000, 1'b0);
    step_samples(5);
    frame_pulse("restart_ok", 12'd0, 12'd0, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
